decode_writeback: RTL
=====================

// Module: decode_writeback
// PURPOSE
//  SEQ decode/writeback stage, directly downstream of fetch. Consumes icode/ifun/rA/rB/valid/error,
//  derives srcA/srcB/dstE/dstM, reads 15x64-bit register file (valA/valB, combinational), writes
//  valE/valM on posedge clk. Holds sticky run/halt/error status that blocks writes after halt.
// PARAMETERS
//  DATA_W    64        register width
//  RSP_INIT  64'h200   reset value of %rsp (reg 4); all other regs reset to 0
// PORTS
//  clk          in   1       clock; all writes on posedge
//  rst          in   1       asynchronous, active-high reset
//  icode        in   4       from fetch
//  ifun         in   4       from fetch (unused except passthrough check)
//  rA, rB       in   4       register specifiers; 4'hF = none
//  instr_valid  in   1       from fetch
//  imem_error   in   1       from fetch
//  cnd          in   1       execute condition (cmovXX write qualifier)
//  valE         in   DATA_W  ALU result
//  valM         in   DATA_W  memory read data
//  srcA, srcB   out  4       decoded read addresses
//  dstE, dstM   out  4       decoded write addresses (dstE already cnd-qualified)
//  valA, valB   out  DATA_W  register read data; 0 when src = 4'hF
//  stat         out  2       0=AOK 1=HLT 2=INS (invalid instr) 3=ADR (imem error)
// BEHAVIOUR
//  - Decode (combinational): srcA = rA for icode 2,4,6,A; 4 for 9,B; else F.
//    srcB = rB for 4,5,6; 4 for 8,9,A,B; else F.
//    dstE = rB for 3,6 and for 2 when cnd=1 (F when cnd=0); 4 for 8,9,A,B; else F.
//    dstM = rA for 5,B; else F. icode > B or instr_valid=0 -> all four = F.
//  - Reads: asynchronous; index F reads 0; reading a reg being written this cycle returns OLD value.
//  - Write enable we = (stat==AOK) && instr_valid && !imem_error && icode!=0.
//  - Posedge clk, we=1: reg[dstE]<=valE if dstE!=F; reg[dstM]<=valM if dstM!=F.
//    dstE==dstM (popq %rsp): valM wins, single write.
//  - Status FSM, sampled posedge clk while stat==AOK: imem_error -> ADR (priority 1);
//    !instr_valid -> INS; icode==0 -> HLT; else stay AOK. HLT/INS/ADR are sticky until rst.
//    Offending instruction performs no writes.
//  - Reset (async, any time incl. mid-write): regs 0 except reg4=RSP_INIT, stat=AOK; takes effect
//    immediately, no partial write survives. Outputs srcA..dstM track inputs even during reset.
//  - Arithmetic: none; all values stored full DATA_W, no truncation/extension.
//  - Latency: decode/read 0 cycles; write visible on valA/valB the cycle after posedge.
// CONFIGURATION
//  REGFILE_DEBUG_EN defined: adds ports dbg_sel (in, 4) and dbg_val (out, DATA_W), async read of
//    reg[dbg_sel], 0 for F; adds no other behaviour. Undefined: ports absent, core unchanged.
// TESTING
//  1 rst pulse -> stat=0, valB=64'h200 with icode=A, all other regs read 0.
//  2 irmovq icode=3,rB=2,valE=64'h1234, clk -> next cycle icode=6,rA=2 gives valA=64'h1234.
//  3 cmov icode=2,rA=1,rB=3,cnd=0 -> dstE=F, reg3 unchanged; cnd=1,valE=7 -> reg3=7.
//  4 popq %rsp icode=B,rA=4,valE=64'h208,valM=64'h55 -> reg4=64'h55 (M priority).
//  5 icode=0 -> stat=1 after clk; subsequent irmovq rB=5,valE=9 -> reg5 stays 0 until rst.
//  6 imem_error=1 with instr_valid=0 -> stat=3 (ADR over INS); rst mid-cycle -> stat=0, regs reset.

Source files
------------

// File: rtl/decode_writeback.sv
// SEQ decode/writeback stage: decode, 15x64 register file, sticky status.
// Optional REGFILE_DEBUG_EN adds a debug read port (dbg_sel/dbg_val).
module decode_writeback #(
    parameter int                 DATA_W   = 64,
    parameter logic [DATA_W-1:0]  RSP_INIT = 64'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
`ifdef REGFILE_DEBUG_EN
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val,
`endif
    output logic [1:0]        stat
);

    localparam logic [1:0] AOK = 2'd0;
    localparam logic [1:0] HLT = 2'd1;
    localparam logic [1:0] INS = 2'd2;
    localparam logic [1:0] ADR = 2'd3;
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP = 4'h4;

    logic [DATA_W-1:0] regs [0:14];
    logic              we;
    logic              unused_ifun;

    assign unused_ifun = ^ifun;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        if (instr_valid) begin
            unique case (icode)
                4'h2: begin
                    srcA = rA;
                    dstE = cnd ? rB : RNONE;
                end
                4'h3: dstE = rB;
                4'h4: begin
                    srcA = rA;
                    srcB = rB;
                end
                4'h5: begin
                    srcB = rB;
                    dstM = rA;
                end
                4'h6: begin
                    srcA = rA;
                    srcB = rB;
                    dstE = rB;
                end
                4'h8: begin
                    srcB = RSP;
                    dstE = RSP;
                end
                4'h9: begin
                    srcA = RSP;
                    srcB = RSP;
                    dstE = RSP;
                end
                4'hA: begin
                    srcA = rA;
                    srcB = RSP;
                    dstE = RSP;
                end
                4'hB: begin
                    srcA = RSP;
                    srcB = RSP;
                    dstE = RSP;
                    dstM = rA;
                end
                default: ;
            endcase
        end
    end

    // Reads see pre-edge contents, so a same-cycle write returns the old value.
    assign valA = (srcA == RNONE) ? '0 : regs[srcA];
    assign valB = (srcB == RNONE) ? '0 : regs[srcB];

`ifdef REGFILE_DEBUG_EN
    assign dbg_val = (dbg_sel == RNONE) ? '0 : regs[dbg_sel];
`endif

    assign we = (stat == AOK) && instr_valid && !imem_error
              && (icode != 4'h0);

    // M port is written last so it wins when dstE == dstM (popq %rsp).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? RSP_INIT : '0;
        end else if (we) begin
            if (dstE != RNONE)
                regs[dstE] <= valE;
            if (dstM != RNONE)
                regs[dstM] <= valM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat <= AOK;
        end else if (stat == AOK) begin
            if (imem_error)
                stat <= ADR;
            else if (!instr_valid)
                stat <= INS;
            else if (icode == 4'h0)
                stat <= HLT;
        end
    end

endmodule
